// File: rtl/traffic_pkg.sv
// Shared channel indices, default timing parameters and counter sizing helper
// for the push-button request path feeding Display_Timer.
package traffic_pkg;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CH_PED = 0;
  localparam int unsigned CH_EM  = 1;

  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned HOLDOFF_CYCLES_DEFAULT  = 16;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce filter, registered rising-edge
// strobe of the debounced level, and the post-issue hold-off counter.
module btn_channel
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic issue,
  output logic rise,
  output logic holdoff_zero
);

  localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HO_W = cnt_width(HOLDOFF_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   db;
  logic [DB_W-1:0]        db_cnt;
  logic [HO_W-1:0]        ho_cnt;
  logic [HO_W-1:0]        ho_next;

  assign s = sync[SYNC_STAGES-1];

  // Hold-off reloads on issue, otherwise counts down and saturates at zero.
  always_comb begin
    ho_next = ho_cnt;
    if (issue) begin
      ho_next = HO_LOAD;
    end else if (ho_cnt != '0) begin
      ho_next = ho_cnt - HO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync         <= '0;
      db           <= 1'b0;
      db_cnt       <= '0;
      rise         <= 1'b0;
      ho_cnt       <= '0;
      holdoff_zero <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      // Level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (s == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= s;
        db_cnt <= '0;
        rise   <= s;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      ho_cnt       <= ho_next;
      holdoff_zero <= (ho_next == '0);
    end
  end

endmodule

// File: rtl/request_conditioner.sv
// Conditions raw pedestrian/emergency buttons into single-cycle request pulses,
// with one-deep pending latches and emergency-first arbitration.
module request_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_btn_raw,
  input  logic em_btn_raw,
  output logic ped_button,
  output logic em_button,
  output logic ped_pending,
  output logic em_pending
);

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] holdoff_zero;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] eligible_c;
  logic [NUM_CH-1:0] issue_c;

  assign raw[CH_PED] = ped_btn_raw;
  assign raw[CH_EM]  = em_btn_raw;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
    ) u_btn_channel (
      .clk          (clk),
      .reset        (reset),
      .raw          (raw[ch]),
      .issue        (issue_c[ch]),
      .rise         (rise[ch]),
      .holdoff_zero (holdoff_zero[ch])
    );
  end

  // Emergency has strict priority; a losing pedestrian request stays pending.
  always_comb begin
    eligible_c = pending & holdoff_zero;
    issue_c    = '0;
    if (eligible_c[CH_EM]) begin
      issue_c[CH_EM] = 1'b1;
    end else if (eligible_c[CH_PED]) begin
      issue_c[CH_PED] = 1'b1;
    end
  end

  // A rise landing on the issuing edge re-arms the latch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending    <= '0;
      ped_button <= 1'b0;
      em_button  <= 1'b0;
    end else begin
      pending    <= (pending & ~issue_c) | rise;
      ped_button <= issue_c[CH_PED];
      em_button  <= issue_c[CH_EM];
    end
  end

  assign ped_pending = pending[CH_PED];
  assign em_pending  = pending[CH_EM];

endmodule

// File: tb/tb_request_conditioner.sv
// Self-checking bench for request_conditioner: directed vectors, hand-written
// corner sequences and random button activity against a window/timestamp model.
`timescale 1ns/1ps
module tb_request_conditioner;
  import traffic_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ped_btn_raw = 1'b0;
  logic em_btn_raw = 1'b0;
  logic ped_button, em_button, ped_pending, em_pending;

  always #1 clk = ~clk;

  request_conditioner dut (
    .clk         (clk),
    .reset       (reset),
    .ped_btn_raw (ped_btn_raw),
    .em_btn_raw  (em_btn_raw),
    .ped_button  (ped_button),
    .em_button   (em_button),
    .ped_pending (ped_pending),
    .em_pending  (em_pending)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state: sample delay line, window of recent synced samples,
  // debounced level, pending flag, and time of last issue per channel.
  int sync_m [2][SYNC];
  int hist_m [2][DEB];
  int db_m   [2];
  int rose_m [2];
  int pend_m [2];
  int btn_m  [2];
  int last_iss [2];
  int n_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    else
      n_pass++;
  endtask

  function automatic void model_step(input int rst_n, input int raw_p, input int raw_e);
    int raw [2];
    int el [2];
    int s;
    bit all_diff;
    n_edge++;
    raw[CH_PED] = raw_p;
    raw[CH_EM]  = raw_e;
    if (rst_n == 0) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < SYNC; i++) sync_m[c][i] = 0;
        for (int i = 0; i < DEB; i++) hist_m[c][i] = 0;
        db_m[c] = 0; rose_m[c] = 0; pend_m[c] = 0; btn_m[c] = 0;
        last_iss[c] = -1000;
      end
    end else begin
      for (int c = 0; c < 2; c++)
        el[c] = (pend_m[c] != 0 && (n_edge - last_iss[c]) > HOLD) ? 1 : 0;
      btn_m[CH_EM]  = el[CH_EM];
      btn_m[CH_PED] = (el[CH_PED] != 0 && el[CH_EM] == 0) ? 1 : 0;
      for (int c = 0; c < 2; c++) begin
        if (btn_m[c] != 0) last_iss[c] = n_edge;
        pend_m[c] = ((pend_m[c] != 0 && btn_m[c] == 0) || rose_m[c] != 0) ? 1 : 0;
        s = sync_m[c][SYNC-1];
        for (int i = DEB - 1; i > 0; i--) hist_m[c][i] = hist_m[c][i-1];
        hist_m[c][0] = s;
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++) if (hist_m[c][i] == db_m[c]) all_diff = 1'b0;
        rose_m[c] = (all_diff && s == 1) ? 1 : 0;
        if (all_diff) db_m[c] = s;
        for (int i = SYNC - 1; i > 0; i--) sync_m[c][i] = sync_m[c][i-1];
        sync_m[c][0] = raw[c];
      end
    end
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(int'(reset), int'(ped_btn_raw), int'(em_btn_raw));
    @(negedge clk);
    check("cycle_outputs", {28'd0, ped_button, em_button, ped_pending, em_pending},
          32'(btn_m[CH_PED] * 8 + btn_m[CH_EM] * 4 + pend_m[CH_PED] * 2 + pend_m[CH_EM]));
    check("no_overlap", {31'd0, ped_button & em_button}, 32'd0);
  endtask

  task automatic apply_reset();
    reset = 1'b0; ped_btn_raw = 1'b0; em_btn_raw = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int ped_start; int ped_len; int em_start; int em_len; int exp_ped; int exp_em;
  } vec_t;

  vec_t vecs [9];
  int first_p, first_e, cnt_p, cnt_e, second_p;

  initial begin
    vecs[0] = '{0, 20, 0, 0, 7, -1};   // clean pedestrian press
    vecs[1] = '{0, 0, 0, 3, -1, -1};   // emergency glitch, one sample short
    vecs[2] = '{0, 20, 0, 20, 8, 7};   // simultaneous: emergency first
    vecs[3] = '{0, 0, 0, 4, -1, 7};    // emergency held exactly the debounce length
    vecs[4] = '{0, 3, 0, 0, -1, -1};   // pedestrian glitch
    vecs[5] = '{0, 20, 2, 20, 7, 9};
    vecs[6] = '{2, 20, 0, 20, 9, 7};
    vecs[7] = '{0, 20, 1, 20, 7, 8};
    vecs[8] = '{1, 20, 0, 20, 8, 7};

    // Reset held with buttons toggling, then released with pedestrian held.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ped_btn_raw = ~ped_btn_raw;
      em_btn_raw  = 1'(i);
      tick();
      check("reset_outputs_zero", {28'd0, ped_button, em_button, ped_pending, em_pending}, 32'd0);
    end
    ped_btn_raw = 1'b1; em_btn_raw = 1'b0; reset = 1'b1;
    first_p = -1; cnt_p = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (ped_button === 1'b1) begin cnt_p++; if (first_p < 0) first_p = t; end
    end
    check("held_through_reset_latency", 32'(first_p), 32'd7);
    check("held_through_reset_count", 32'(cnt_p), 32'd1);

    // Directed vectors.
    for (int v = 0; v < 9; v++) begin
      apply_reset();
      first_p = -1; first_e = -1; cnt_p = 0; cnt_e = 0;
      for (int t = 0; t < 40; t++) begin
        ped_btn_raw = (t >= vecs[v].ped_start && t < vecs[v].ped_start + vecs[v].ped_len);
        em_btn_raw  = (t >= vecs[v].em_start && t < vecs[v].em_start + vecs[v].em_len);
        tick();
        if (ped_button === 1'b1) begin cnt_p++; if (first_p < 0) first_p = t; end
        if (em_button === 1'b1) begin cnt_e++; if (first_e < 0) first_e = t; end
      end
      check($sformatf("vec%0d_ped_edge", v), 32'(first_p), 32'(vecs[v].exp_ped));
      check($sformatf("vec%0d_em_edge", v), 32'(first_e), 32'(vecs[v].exp_em));
      check($sformatf("vec%0d_ped_count", v), 32'(cnt_p), (vecs[v].exp_ped >= 0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_em_count", v), 32'(cnt_e), (vecs[v].exp_em >= 0) ? 32'd1 : 32'd0);
    end

    // Hold-off: second press debounced at 21, pending from 22, issued at 7+17.
    apply_reset();
    first_p = -1; second_p = -1; cnt_p = 0;
    for (int t = 0; t < 40; t++) begin
      ped_btn_raw = (t < 10) || (t >= 16 && t < 30);
      tick();
      if (ped_button === 1'b1) begin
        cnt_p++;
        if (first_p < 0) first_p = t; else if (second_p < 0) second_p = t;
      end
      if (t == 22 || t == 23) check("holdoff_pending_wait", {31'd0, ped_pending}, 32'd1);
    end
    check("holdoff_first", 32'(first_p), 32'd7);
    check("holdoff_second", 32'(second_p), 32'd24);
    check("holdoff_count", 32'(cnt_p), 32'd2);

    // Reset mid-operation while a request waits out its hold-off.
    apply_reset();
    for (int t = 0; t < 23; t++) begin
      ped_btn_raw = (t < 10) || (t >= 16);
      tick();
    end
    check("midreset_pending_before", {31'd0, ped_pending}, 32'd1);
    ped_btn_raw = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_pending_cleared", {31'd0, ped_pending}, 32'd0);
    cnt_p = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (ped_button === 1'b1) cnt_p++;
    end
    check("midreset_no_pulse", 32'(cnt_p), 32'd0);

    // Random button activity with occasional resets.
    apply_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) ped_btn_raw = ~ped_btn_raw;
      if ($urandom_range(0, 5) == 0) em_btn_raw = ~em_btn_raw;
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
